// File: rtl/react_timer.sv
// Reaction-time game controller: random red-screen wait, then counts ms until the key is pressed.
// Score is kept in 3-digit BCD and saturates at 999 ms.
module react_timer #(
  parameter int MS_DIV      = 50000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 11
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        keyPress,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic        oTooSoon,
  output logic        oScoreValid
);

  localparam int PW = (MS_DIV > 2) ? $clog2(MS_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GO   = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic           key_d_reg;
  logic [PW-1:0]  presc_reg, presc_next;
  logic [11:0]    wait_reg, wait_next;
  logic [15:0]    lfsr_reg, lfsr_next;
  logic [11:0]    score_reg, score_next;
  logic           too_soon_reg, too_soon_next;
  logic           valid_reg, valid_next;

  logic           press;
  logic           counting;
  logic           tick;
  logic [11:0]    wait_load;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign press     = keyPress & ~key_d_reg;
  assign counting  = (state_reg == ARM) || (state_reg == GO);
  assign tick      = counting && (presc_reg == PW'(MS_DIV - 1));
  assign wait_load = 12'(MIN_WAIT_MS) + {{(12 - RAND_BITS){1'b0}}, lfsr_reg[RAND_BITS-1:0]};
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
  assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

  always_comb begin
    state_next    = state_reg;
    presc_next    = counting ? (tick ? '0 : presc_reg + PW'(1)) : '0;
    wait_next     = wait_reg;
    score_next    = score_reg;
    too_soon_next = too_soon_reg;
    valid_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press) begin
          state_next    = ARM;
          wait_next     = wait_load;
          presc_next    = '0;
          too_soon_next = 1'b0;
        end
      end
      ARM: begin
        // A press on the same edge as the final tick still counts as early
        if (press) begin
          state_next    = SHOW;
          too_soon_next = 1'b1;
          score_next    = 12'h000;
        end else if (tick) begin
          if (wait_reg <= 12'd1) begin
            state_next = GO;
            wait_next  = 12'd0;
            presc_next = '0;
            score_next = 12'h000;
          end else begin
            wait_next = wait_reg - 12'd1;
          end
        end
      end
      GO: begin
        if (press) begin
          state_next = SHOW;
          valid_next = 1'b1;
        end else if (tick) begin
          score_next = bcd_inc(score_reg);
        end
      end
      SHOW: begin
        if (press) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state_reg    <= IDLE;
      key_d_reg    <= 1'b0;
      presc_reg    <= '0;
      wait_reg     <= 12'd0;
      lfsr_reg     <= 16'hACE1;
      score_reg    <= 12'h000;
      too_soon_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      key_d_reg    <= keyPress;
      presc_reg    <= presc_next;
      wait_reg     <= wait_next;
      lfsr_reg     <= lfsr_next;
      score_reg    <= score_next;
      too_soon_reg <= too_soon_next;
      valid_reg    <= valid_next;
    end
  end

  assign reactScreen  = state_reg;
  assign currentScore = score_reg;
  assign oTooSoon     = too_soon_reg;
  assign oScoreValid  = valid_reg;

endmodule

// File: tb/tb_react_timer.sv
// Scoreboard bench for react_timer: stimulus predicts every screen change (cycle, screen, score, flags),
// a negedge monitor pops and compares whenever the screen changes and checks the score-valid pulse.
module tb_react_timer;
  localparam int MS_DIV    = 4;
  localparam int MIN_WAIT  = 2;
  localparam int RAND_BITS = 1;

  logic        clk = 1'b0;
  logic        iResetn = 1'b0;
  logic        keyPress = 1'b0;
  logic [1:0]  reactScreen;
  logic [11:0] currentScore;
  logic        oTooSoon;
  logic        oScoreValid;

  react_timer #(.MS_DIV(MS_DIV), .MIN_WAIT_MS(MIN_WAIT), .RAND_BITS(RAND_BITS)) dut (
    .clk(clk), .iResetn(iResetn), .keyPress(keyPress),
    .reactScreen(reactScreen), .currentScore(currentScore),
    .oTooSoon(oTooSoon), .oScoreValid(oScoreValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] screen;
    logic [11:0] score;
    logic       too_soon;
    logic       valid;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          valid_cyc = -1;
  bit          mon_en = 0;
  logic [1:0]  prev_screen = 2'd0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [11:0] m_score = 12'h000;
  logic        m_too_soon = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference random source: the same polynomial, written as the classic shift/xor recurrence
  always @(posedge clk) begin
    if (!iResetn) m_lfsr <= 16'hACE1;
    else m_lfsr <= (m_lfsr >> 1) | (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
  end

  function automatic logic [11:0] to_bcd(int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int c, logic [1:0] s, logic [11:0] sc, logic ts, logic v);
    exp_t x;
    x.cyc = c; x.screen = s; x.score = sc; x.too_soon = ts; x.valid = v;
    sb.push_back(x);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (reactScreen !== prev_screen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_screen: got %0d from %0d, none expected (cycle %0d)", reactScreen, prev_screen, cyc);
        end else begin
          e = sb.pop_front();
          chk("change_cycle", cyc, e.cyc);
          chk("screen", int'(reactScreen), int'(e.screen));
          chk("score", int'(currentScore), int'(e.score));
          chk("too_soon", int'(oTooSoon), int'(e.too_soon));
          if (e.valid) valid_cyc = cyc;
          $display("event cyc=%0d screen=%0d score=%03h too_soon=%0d valid=%0d", cyc, reactScreen, currentScore, oTooSoon, oScoreValid);
        end
        prev_screen = reactScreen;
      end
      chk("score_valid", int'(oScoreValid), (cyc == valid_cyc) ? 1 : 0);
    end
  end

  // One game round. d = edges after ARM entry at which the reaction press lands (relative to
  // the end of the wait when rel=1); hold = cycles the starting press is held high.
  task automatic do_round(int d_in, bit rel, int hold, int show_wait);
    int w, e0, d, p;
    w  = MIN_WAIT + int'(m_lfsr % (16'd1 << RAND_BITS));
    d  = rel ? (w * MS_DIV + d_in) : d_in;
    if (d < hold + 1) d = hold + 1;
    e0 = cyc + 1;
    keyPress = 1'b1;
    push(e0, 2'd1, m_score, 1'b0, 1'b0);
    if (d <= w * MS_DIV) begin
      m_score = 12'h000;
      m_too_soon = 1'b1;
      push(e0 + d, 2'd3, m_score, 1'b1, 1'b0);
    end else begin
      push(e0 + w * MS_DIV, 2'd2, 12'h000, 1'b0, 1'b0);
      p = d - w * MS_DIV;
      m_score = to_bcd((p - 1) / MS_DIV);
      m_too_soon = 1'b0;
      push(e0 + d, 2'd3, m_score, 1'b0, 1'b1);
    end
    step(hold);
    keyPress = 1'b0;
    step(d - hold);
    keyPress = 1'b1;
    step(1);
    keyPress = 1'b0;
    step(show_wait);
    push(cyc + 1, 2'd0, m_score, m_too_soon, 1'b0);
    keyPress = 1'b1;
    step(1);
    keyPress = 1'b0;
    step(1 + int'($urandom_range(0, 3)));
  endtask

  // Enter GO, let the score reach 012, then pulse reset with the key already high.
  task automatic reset_mid_go();
    int w, e0;
    w  = MIN_WAIT + int'(m_lfsr % (16'd1 << RAND_BITS));
    e0 = cyc + 1;
    keyPress = 1'b1;
    push(e0, 2'd1, m_score, 1'b0, 1'b0);
    push(e0 + w * MS_DIV, 2'd2, 12'h000, 1'b0, 1'b0);
    step(1);
    keyPress = 1'b0;
    step(w * MS_DIV + 12 * MS_DIV + 1);
    chk("score_before_reset", int'(currentScore), int'(to_bcd(12)));
    iResetn = 1'b0;
    keyPress = 1'b1;
    push(cyc + 1, 2'd0, 12'h000, 1'b0, 1'b0);
    step(1);
    iResetn = 1'b1;
    m_score = 12'h000;
    m_too_soon = 1'b0;
  endtask

  initial begin
    iResetn = 1'b0;
    keyPress = 1'b0;
    step(3);
    chk("reset_screen", int'(reactScreen), 0);
    chk("reset_score", int'(currentScore), 0);
    chk("reset_too_soon", int'(oTooSoon), 0);
    chk("reset_valid", int'(oScoreValid), 0);
    iResetn = 1'b1;
    mon_en = 1'b1;

    do_round(1, 1'b0, 1, 3);            // press one cycle into the wait
    do_round(0, 1'b1, 1, 2);            // press on the final wait tick
    do_round(1, 1'b1, 1, 2);            // first GO cycle: score 000
    do_round(MS_DIV, 1'b1, 1, 2);       // press coincides with first GO tick
    do_round(MS_DIV + 1, 1'b1, 1, 2);   // just after first tick: 001
    do_round(37 * MS_DIV + 1, 1'b1, 1, 4);
    do_round(60, 1'b0, 50, 3);          // key held 50 cycles gives one press
    do_round(1005 * MS_DIV + 1, 1'b1, 1, 3);
    reset_mid_go();
    do_round(3 * MS_DIV + 2, 1'b1, 1, 2);  // key was already high out of reset

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_round(-int'($urandom_range(0, 7)), 1'b1, 1, int'($urandom_range(1, 4)));
      else
        do_round(int'($urandom_range(1, 300)), 1'b1, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
    end

    step(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/react_timer.md
REACT_TIMER -- requirements
Module: react_timer

Interface
REQ-001 SHALL have parameter MS_DIV, default 50000, clk cycles per 1 ms tick (>=2).
REQ-002 SHALL have parameter MIN_WAIT_MS, default 1000, fixed part of red-screen wait in ms.
REQ-003 SHALL have parameter RAND_BITS, default 11, number of LFSR bits added to the wait (1..11).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 iResetn  input  1  synchronous, active-low reset.
REQ-006 keyPress  input  1  key level, synchronous to clk; a press is a 0->1 edge.
REQ-007 reactScreen  output  2  screen select to the VGA stage: 0 blue/idle, 1 red/wait, 2 green/go, 3 score.
REQ-008 currentScore  output  12  reaction time in ms, 3 BCD digits [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 oTooSoon  output  1  high while the score screen reports an early press.
REQ-010 oScoreValid  output  1  one-cycle pulse when a valid reaction time is latched.

Function
REQ-011 Press detect SHALL be press = keyPress & ~key_d, where key_d is keyPress registered each cycle.
REQ-012 States SHALL be IDLE, ARM, GO, SHOW driving reactScreen 0, 1, 2, 3 respectively, registered.
REQ-013 State changes SHALL take effect on the same clk edge at which press is true (reactScreen valid the following cycle).
REQ-014 IDLE: press -> ARM; load wait counter W = MIN_WAIT_MS + lfsr[RAND_BITS-1:0]; clear prescaler; clear oTooSoon.
REQ-015 Prescaler SHALL count 0..MS_DIV-1 in ARM and GO only; tick = (count == MS_DIV-1), then wrap to 0.
REQ-016 ARM: each tick decrements W; the tick that brings W to 0 SHALL move to GO, clear prescaler, clear currentScore to 12'h000.
REQ-017 ARM: press before that tick -> SHOW with oTooSoon=1, currentScore=12'h000, no oScoreValid.
REQ-018 ARM: press and W-reaching-0 tick in the same cycle SHALL be treated as too soon (REQ-017).
REQ-019 GO: each tick SHALL BCD-increment currentScore (ones 9->0 carries to tens, tens 9->0 carries to hundreds).
REQ-020 currentScore SHALL saturate at 12'h999; further ticks ignored; state stays GO until press.
REQ-021 GO: press -> SHOW, oScoreValid=1 for exactly that next cycle; a tick coinciding with press SHALL NOT increment.
REQ-022 SHOW: currentScore and oTooSoon held; press -> IDLE; currentScore retained until next GO entry.
REQ-023 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, free-running every cycle in all states, seed 16'hACE1, never all-zero.
REQ-024 W counter SHALL be 12 bits, sufficient for MIN_WAIT_MS + 2^RAND_BITS - 1 <= 4095.
REQ-025 keyPress held high SHALL produce only one press; a new press requires keyPress low for >=1 cycle.

Reset
REQ-026 iResetn=0 at a clk edge SHALL set state IDLE, reactScreen=0, currentScore=12'h000, oTooSoon=0, oScoreValid=0, key_d=0, prescaler=0, W=0, LFSR=16'hACE1.
REQ-027 Reset SHALL take priority over press and tick in any state, including mid-ARM and mid-GO.
REQ-028 keyPress high while leaving reset SHALL count as a press on the first non-reset edge (key_d=0).

Verification (MS_DIV=4, MIN_WAIT_MS=2, RAND_BITS=1)
REQ-029 Reset, 1-cycle press -> reactScreen 0->1; after (2+lfsr[0])*4 cycles reactScreen=2, currentScore=000.
REQ-030 In GO, wait 37 ticks (148 cycles), press -> reactScreen=3, currentScore=12'h037, oScoreValid high 1 cycle, oTooSoon=0.
REQ-031 In ARM, press after 1 cycle -> reactScreen=3, oTooSoon=1, currentScore=000, oScoreValid never asserted.
REQ-032 In GO, no press for 1200 ticks -> currentScore=12'h999, reactScreen stays 2; press -> SHOW with 999.
REQ-033 keyPress held high 50 cycles in IDLE -> exactly one transition to ARM; later press in SHOW -> reactScreen=0.
REQ-034 iResetn=0 for 1 cycle mid-GO with currentScore=12'h012 -> next cycle reactScreen=0, currentScore=000, all flags 0.
